// File: rtl/cmplt_arb.sv
// Round-robin arbiter sharing one signed/unsigned less-than comparator among NREQ requesters.
// Optional equality output rsp_eq is enabled by defining CMPLT_ARB_EQ_EN.
module cmplt_arb #(
  parameter int WIDTH    = 16,
  parameter int NREQ     = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  input  logic [NREQ-1:0]          req_signed,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_WIDTH-1:0]      rsp_id,
  output logic                     rsp_lt
`ifdef CMPLT_ARB_EQ_EN
  ,
  output logic                     rsp_eq
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and a holder keeps valid/data stable until the transfer.

  localparam logic [ID_WIDTH:0] NREQ_W = (ID_WIDTH + 1)'(NREQ);

  logic [ID_WIDTH-1:0] rr_ptr;
  logic                s1_valid;
  logic [WIDTH-1:0]    s1_a;
  logic [WIDTH-1:0]    s1_b;
  logic                s1_signed;
  logic [ID_WIDTH-1:0] s1_id;
  logic                s1_lt;

  logic                adv1;
  logic                adv2;
  logic                accept;
  logic                grant_found;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [ID_WIDTH:0]   shamt;
  logic [2*NREQ-1:0]   dbl_valid;
  logic [NREQ-1:0]     rot_valid;
  logic [ID_WIDTH:0]   idx_sum;

  assign adv2 = ~rsp_valid | rsp_ready;
  assign adv1 = ~s1_valid | adv2;

  // Rotate the request vector so bit 0 is the requester just after rr_ptr.
  assign shamt     = {1'b0, rr_ptr} + (ID_WIDTH + 1)'(1);
  assign dbl_valid = {req_valid, req_valid};
  assign rot_valid = NREQ'(dbl_valid >> shamt);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && rot_valid[k]) begin
        grant_found = 1'b1;
        idx_sum     = shamt + (ID_WIDTH + 1)'(k);
        if (idx_sum >= NREQ_W) begin
          idx_sum = idx_sum - NREQ_W;
        end
        grant_idx = ID_WIDTH'(idx_sum);
      end
    end
  end

  // rst_n gates ready so nothing is offered while the block is held in reset.
  assign accept = grant_found & adv1 & rst_n;

  always_comb begin
    req_ready = '0;
    if (grant_found && rst_n) begin
      req_ready[grant_idx] = adv1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_signed <= 1'b0;
      s1_id     <= '0;
      rr_ptr    <= ID_WIDTH'(NREQ - 1);
    end else begin
      if (adv1) begin
        s1_valid <= accept;
      end
      if (accept) begin
        s1_a      <= req_a[grant_idx*WIDTH +: WIDTH];
        s1_b      <= req_b[grant_idx*WIDTH +: WIDTH];
        s1_signed <= req_signed[grant_idx];
        s1_id     <= grant_idx;
        rr_ptr    <= grant_idx;
      end
    end
  end

  assign s1_lt = s1_signed ? ($signed(s1_a) < $signed(s1_b)) : (s1_a < s1_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_lt    <= 1'b0;
`ifdef CMPLT_ARB_EQ_EN
      rsp_eq    <= 1'b0;
`endif
    end else if (adv2) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_id <= s1_id;
        rsp_lt <= s1_lt;
`ifdef CMPLT_ARB_EQ_EN
        rsp_eq <= (s1_a == s1_b);
`endif
      end
    end
  end

endmodule

// File: tb/tb_cmplt_arb.sv
// Self-checking bench for cmplt_arb: scoreboard of tagged results plus per-scenario checks.
module tb_cmplt_arb;

  localparam int WIDTH    = 16;
  localparam int NREQ     = 4;
  localparam int ID_WIDTH = 2;
`ifdef CMPLT_ARB_EQ_EN
  localparam int EW = ID_WIDTH + 2;
`else
  localparam int EW = ID_WIDTH + 1;
`endif

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_signed;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_WIDTH-1:0]   rsp_id;
  logic                  rsp_lt;
`ifdef CMPLT_ARB_EQ_EN
  logic                  rsp_eq;
`endif
  logic [EW-1:0]         rsp_act;

  int tests = 0;
  int fails = 0;
  logic [EW-1:0]   exp_q[$];
  int              grant_log[$];
  int              model_rr;
  logic [NREQ-1:0] acc_mask;

  cmplt_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_WIDTH(ID_WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_lt     (rsp_lt)
`ifdef CMPLT_ARB_EQ_EN
    ,
    .rsp_eq     (rsp_eq)
`endif
  );

  assign rsp_act = {rsp_id, rsp_lt
`ifdef CMPLT_ARB_EQ_EN
    , rsp_eq
`endif
  };

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // Reference model
  function automatic logic model_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic s);
    logic [WIDTH-1:0] flip;
    flip = '0;
    flip[WIDTH-1] = s;
    return (a ^ flip) < (b ^ flip);
  endfunction

  function automatic logic [EW-1:0] model_rsp(input int id, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b, input logic s);
`ifdef CMPLT_ARB_EQ_EN
    return {ID_WIDTH'(id), model_lt(a, b, s), (a == b)};
`else
    return {ID_WIDTH'(id), model_lt(a, b, s)};
`endif
  endfunction

  function automatic int model_grant(input int rr, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  // Monitor: grant check, accept capture (push) and response scoreboard (pop)
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    logic [EW-1:0]   exp_v;
    int g;
    if (!rst_n) begin
      model_rr = NREQ - 1;
      acc_mask = '0;
    end else begin
      acc_mask = req_valid & req_ready;
      g = model_grant(model_rr, req_valid);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      if (!rsp_valid || rsp_ready || req_ready != '0) begin
        tests++;
        if (req_ready !== exp_rdy) begin
          fails++;
          $display("FAIL grant: req_ready=%b expected %b (req_valid=%b)", req_ready, exp_rdy, req_valid);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i]) begin
          exp_q.push_back(model_rsp(i, req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH], req_signed[i]));
          grant_log.push_back(i);
          model_rr = i;
        end
      end
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard_unexpected: got %h with nothing expected", rsp_act);
        end else begin
          exp_v = exp_q.pop_front();
          if (rsp_act !== exp_v) begin
            fails++;
            $display("FAIL scoreboard_rsp: got {id,lt..}=%h expected %h", rsp_act, exp_v);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_signed[i] = s;
    req_valid[i]  = 1'b1;
  endtask

  task automatic step_drop();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc_mask;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      step_drop();
      if (exp_q.size() == 0 && !rsp_valid && req_valid == '0) done = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results still expected", exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    req_a = '0;
    req_b = '0;
    req_signed = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    tests++;
    if (rsp_id !== '0) begin fails++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    tests++;
    if (rsp_lt !== 1'b0) begin fails++; $display("FAIL reset_rsp_lt: got %b expected 0", rsp_lt); end
    tests++;
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    rst_n = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready); end
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();
  endtask

  task automatic test_single();
    logic exp_lt;
    for (int s = 0; s < 2; s++) begin
      exp_lt = (s == 1);
      set_req(2, 16'hFFFF, 16'h0001, s[0]);
      step_drop();
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_early: rsp_valid=%b expected 0", rsp_valid); end
      @(posedge clk);
      #1;
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_lt !== exp_lt) begin
        fails++;
        $display("FAIL single_s%0d: valid=%b id=%0d lt=%b expected 1 2 %b", s, rsp_valid, rsp_id, rsp_lt, exp_lt);
      end
      drain();
    end
  endtask

  task automatic test_contention();
    logic exp_v;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 16'hFFFE, 16'hFFFF, 1'b1);
    grant_log.delete();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 7) req_valid = '0;
      @(negedge clk);
      exp_v = (c >= 1 && c <= 8);
      tests++;
      if (rsp_valid !== exp_v) begin
        fails++;
        $display("FAIL contention_rate c=%0d: rsp_valid=%b expected %b", c, rsp_valid, exp_v);
      end
    end
    tests++;
    if (grant_log.size() != 8) begin
      fails++;
      $display("FAIL contention_count: %0d accepts expected 8", grant_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (grant_log[i] != i % NREQ) begin
          fails++;
          $display("FAIL contention_order[%0d]: got %0d expected %0d", i, grant_log[i], i % NREQ);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_req(0, 16'd3, 16'd5, 1'b0);
    set_req(1, 16'h8000, 16'h0001, 1'b1);
    set_req(2, 16'd7, 16'd7, 1'b0);
    step_drop();
    step_drop();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_lt !== 1'b1 || req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL stall c=%0d: valid=%b id=%0d lt=%b ready=%b expected 1 0 1 0000",
                 c, rsp_valid, rsp_id, rsp_lt, req_ready);
      end
      step_drop();
    end
    rsp_ready = 1'b1;
    drain();
  endtask

  task automatic test_fairness();
    set_req(1, 16'd10, 16'd20, 1'b0);
    drain();
    grant_log.delete();
    set_req(1, 16'd10, 16'd20, 1'b0);
    set_req(3, 16'd9, 16'd2, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    req_valid = '0;
    tests++;
    if (grant_log.size() != 6) begin
      fails++;
      $display("FAIL fairness_count: %0d grants expected 6", grant_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (grant_log[i] != ((i % 2 == 0) ? 3 : 1)) begin
          fails++;
          $display("FAIL fairness_order[%0d]: got %0d expected %0d", i, grant_log[i], (i % 2 == 0) ? 3 : 1);
        end
      end
    end
    drain();
  endtask

  task automatic test_mid_reset();
    rsp_ready = 1'b0;
    set_req(0, 16'd1, 16'd2, 1'b0);
    set_req(1, 16'd4, 16'd2, 1'b0);
    step_drop();
    step_drop();
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1) begin fails++; $display("FAIL midrst_fill: rsp_valid=%b expected 1", rsp_valid); end
    #2;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL midrst_async: rsp_valid=%b req_ready=%b expected 0 0000", rsp_valid, req_ready);
    end
    exp_q.delete();
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b0) begin fails++; $display("FAIL midrst_stale c=%0d: rsp_valid=%b expected 0", c, rsp_valid); end
    end
  endtask

`ifdef CMPLT_ARB_EQ_EN
  task automatic test_eq();
    for (int s = 0; s < 2; s++) begin
      set_req(0, 16'h8000, 16'h8000, s[0]);
      step_drop();
      @(posedge clk);
      #1;
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b1 || rsp_eq !== 1'b1 || rsp_lt !== 1'b0) begin
        fails++;
        $display("FAIL eq_s%0d: valid=%b eq=%b lt=%b expected 1 1 0", s, rsp_valid, rsp_eq, rsp_lt);
      end
      drain();
    end
  endtask
`endif

  task automatic test_random();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          a = WIDTH'($urandom_range(0, 65535));
          b = ($urandom_range(0, 3) == 0) ? a : WIDTH'($urandom_range(0, 65535));
          set_req(i, a, b, $urandom_range(0, 1) == 1);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step_drop();
    end
    rsp_ready = 1'b1;
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_fairness();
    test_mid_reset();
`ifdef CMPLT_ARB_EQ_EN
    test_eq();
`endif
    test_random();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL final_queue: %0d results never produced, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmplt_arb.md
Name: cmplt_arb

Overview:
- Round-robin arbiter and pipeline controller that shares one signed/unsigned less-than comparator (cmplt) between NREQ requesters.
- Each requester presents an operand pair and a signedness flag through a valid/ready handshake.
- The block grants one request per cycle, registers the operands, evaluates a < b, and returns the result tagged with the requester ID.
- Back-pressure comes from a single response port.

Parameters:
- WIDTH, 16, operand width in bits.
- NREQ, 4, number of requesters (>= 2).
- ID_WIDTH, 2, width of the requester ID; must satisfy 2^ID_WIDTH >= NREQ.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept. One-hot or zero.
- req_a  input  NREQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand b; same packing as req_a.
- req_signed  input  NREQ  per-requester signed-compare flag.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_WIDTH  index of the requester that issued the result.
- rsp_lt  output  1  1 when a < b under the requested signedness.

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_id=0, rsp_lt=0, s1_valid=0, rr_ptr=NREQ-1. req_ready is combinational and therefore 0 while rst_n=0.
- Pipeline: S1 is the operand register (a, b, is_signed, id, s1_valid). S2 is the output register (rsp_*).
  - adv2 = ~rsp_valid | rsp_ready.
  - adv1 = ~s1_valid | adv2.
- Arbitration (combinational):
  - Search starts at (rr_ptr+1) mod NREQ and proceeds upward with wrap.
  - The first index with req_valid=1 is granted.
  - req_ready[g] = adv1 for the granted index g. All other req_ready bits are 0.
- Accept: on req_valid[g] & req_ready[g], S1 loads req_a/req_b/req_signed slice g and id=g, and rr_ptr<=g. rr_ptr does not change on cycles with no accept.
- S1 to S2: on adv2 & s1_valid, S2 loads rsp_lt = cmplt(S1 a, S1 b, S1 is_signed) and rsp_id = S1 id, and sets rsp_valid=1.
  - On adv2 & ~s1_valid: rsp_valid<=0.
  - On adv1 with no accept: s1_valid<=0.
- Comparison rule:
  - Unsigned: a < b as unsigned WIDTH-bit integers.
  - Signed: two's complement. Equal operands give 0.
- Latency: accept at edge k gives rsp_valid=1 after edge k+1 (2 cycles from request to response visible).
- Throughput: 1 result per cycle when rsp_ready is held high.
- Stall: rsp_valid=1 & rsp_ready=0 freezes S2 and S1. If s1_valid=1, all req_ready are 0. Outputs stay stable until consumed.
- Requester rule: the requester holds req_valid and its operands stable until accepted. The arbiter may re-target the grant on any cycle in which that requester is not accepted.
- Simultaneous consume and fill: when the S2 handshake and the S1 to S2 load occur on the same edge, the new result replaces the old one with no bubble.
- Reset mid-operation: in-flight S1 and S2 contents are discarded and no response is emitted for them.

Optional Feature:
- Macro: CMPLT_ARB_EQ_EN.
- Defined: adds output port rsp_eq (1 bit, reset 0), registered with rsp_lt; rsp_eq = (S1 a == S1 b), independent of signedness.
- Undefined: no rsp_eq port and no equality logic.

Test Plan:
- Reset: hold rst_n=0 with req_valid=4'hF → rsp_valid=0, rsp_id=0, rsp_lt=0, req_ready=0. After release, the first grant goes to requester 0.
- Single request, requester 2, a=16'hFFFF, b=1:
  - req_signed=0 → rsp_lt=0, rsp_id=2, rsp_valid 2 cycles after req_valid.
  - req_signed=1 → rsp_lt=1.
- Contention: req_valid=4'hF held for 8 cycles, rsp_ready=1 → accepts in order 0,1,2,3,0,1,2,3 and one rsp_valid per cycle. Operands a=-2, b=-1 signed give rsp_lt=1 for every response.
- Back-pressure: 3 queued requests with rsp_ready=0 for 5 cycles → rsp_valid=1 and rsp_id/rsp_lt stable, req_ready=0. Release → remaining results follow back-to-back with no loss or duplication.
- Fairness skip: req_valid=4'b1010 after the last grant was 1 → next grant is 3, then 1. Requesters 0 and 2 are never granted.
- Mid-operation reset: assert rst_n=0 with S1 and S2 full → rsp_valid=0 immediately (async). No stale response after release.
- With CMPLT_ARB_EQ_EN: a=b=16'h8000 → rsp_eq=1, rsp_lt=0 in both signed modes.
